// File: rtl/dual_fifo_tx_scheduler.sv
// Round-robin scheduler that feeds two FIFO channels into one serializer, one burst per grant.
// Optional macro TX_CHANNEL_TAG_EN prefixes every grant with a channel tag word.
`ifndef BUFF_SIZE
`define BUFF_SIZE 8
`endif

module dual_fifo_tx_scheduler #(
  parameter int DATA_W    = `BUFF_SIZE,
  parameter int BURST_LEN = 4
`ifdef TX_CHANNEL_TAG_EN
  , parameter logic [DATA_W-1:0] TAG_BASE = DATA_W'('hF0)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo1_dout,
  output logic              fifo1_rd_en,
  input  logic              fifo2_empty,
  input  logic [DATA_W-1:0] fifo2_dout,
  output logic              fifo2_rd_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              active_ch,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [2:0] {IDLE, ARB, TAG, READ, LATCH, SEND} state_t;

  state_t              state_reg, state_next;
  logic                rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]    burst_cnt_reg, burst_cnt_next;
  logic                active_ch_reg, active_ch_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic                tx_valid_reg, tx_valid_next;

  logic pref_empty, other_empty, grant_ok, grant_ch, active_empty, last_word;

  // Preferred channel first, the other one only if the preferred FIFO is empty.
  assign pref_empty   = rr_ptr_reg ? fifo2_empty : fifo1_empty;
  assign other_empty  = rr_ptr_reg ? fifo1_empty : fifo2_empty;
  assign grant_ok     = !(pref_empty && other_empty);
  assign grant_ch     = pref_empty ? !rr_ptr_reg : rr_ptr_reg;
  assign active_empty = active_ch_reg ? fifo2_empty : fifo1_empty;
  assign last_word    = (burst_cnt_reg == CNT_W'(BURST_LEN - 1)) || active_empty;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    active_ch_next = active_ch_reg;
    tx_data_next   = tx_data_reg;
    tx_valid_next  = tx_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ARB;
      end
      ARB: begin
        if (!start) begin
          state_next = IDLE;
        end else if (grant_ok) begin
          active_ch_next = grant_ch;
          burst_cnt_next = '0;
`ifdef TX_CHANNEL_TAG_EN
          tx_data_next  = TAG_BASE + DATA_W'(grant_ch);
          tx_valid_next = 1'b1;
          state_next    = TAG;
`else
          state_next = READ;
`endif
        end
      end
`ifdef TX_CHANNEL_TAG_EN
      TAG: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = start ? READ : IDLE;
        end
      end
`endif
      READ:  state_next = LATCH;
      LATCH: begin
        tx_data_next  = active_ch_reg ? fifo2_dout : fifo1_dout;
        tx_valid_next = 1'b1;
        state_next    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (!start) begin
            state_next = IDLE;
          end else if (last_word) begin
            rr_ptr_next = !active_ch_reg;
            state_next  = ARB;
          end else begin
            burst_cnt_next = burst_cnt_reg + CNT_W'(1);
            state_next     = READ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      burst_cnt_reg <= '0;
      active_ch_reg <= 1'b0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      active_ch_reg <= active_ch_next;
      tx_data_reg   <= tx_data_next;
      tx_valid_reg  <= tx_valid_next;
    end
  end

  // Pop strobes decode straight from the registered state, so each READ gives one pulse.
  assign fifo1_rd_en = (state_reg == READ) && !active_ch_reg;
  assign fifo2_rd_en = (state_reg == READ) && active_ch_reg;
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign active_ch   = active_ch_reg;
  assign busy        = (state_reg != IDLE) && (state_reg != ARB);

endmodule

// File: tb/tb_dual_fifo_tx_scheduler.sv
// Randomized bench for dual_fifo_tx_scheduler: transaction-level round-robin model vs. observed tx stream.
module tb_dual_fifo_tx_scheduler;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam logic [DW-1:0] TAGB = 8'hF0;
`ifdef TX_CHANNEL_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, tx_ready;
  logic fifo1_empty, fifo2_empty, fifo1_rd_en, fifo2_rd_en;
  logic [DW-1:0] fifo1_dout, fifo2_dout, tx_data;
  logic tx_valid, active_ch, busy;

  dual_fifo_tx_scheduler #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fifo1_empty(fifo1_empty), .fifo1_dout(fifo1_dout), .fifo1_rd_en(fifo1_rd_en),
    .fifo2_empty(fifo2_empty), .fifo2_dout(fifo2_dout), .fifo2_rd_en(fifo2_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .active_ch(active_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple FIFOs with registered read data; pointers only ever grow.
  logic [DW-1:0] mem1 [0:1023];
  logic [DW-1:0] mem2 [0:1023];
  int wr1 = 0, wr2 = 0, rd1 = 0, rd2 = 0;
  assign fifo1_empty = (rd1 == wr1);
  assign fifo2_empty = (rd2 == wr2);
  always @(posedge clk) begin
    if (fifo1_rd_en && rd1 != wr1) begin fifo1_dout <= mem1[rd1]; rd1 <= rd1 + 1; end
    if (fifo2_rd_en && rd2 != wr2) begin fifo2_dout <= mem2[rd2]; rd2 <= rd2 + 1; end
  end

  int total = 0, bad = 0;
  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: what each FIFO holds, the preferred channel, expected stream.
  int mq1[$], mq2[$];
  int exp_d[$], exp_c[$], got_d[$], got_c[$];
  bit mptr = 1'b0;

  task automatic load(input int ch, input logic [DW-1:0] v);
    if (ch == 0) begin mem1[wr1] = v; wr1++; mq1.push_back(int'(v)); end
    else         begin mem2[wr2] = v; wr2++; mq2.push_back(int'(v)); end
  endtask

  // One grant: up to maxw words (maxw < BL means start is dropped, pointer kept).
  task automatic model_grant(input int maxw);
    bit ch;
    int n = 0;
    if (mptr == 1'b0) ch = (mq1.size() > 0) ? 1'b0 : 1'b1;
    else              ch = (mq2.size() > 0) ? 1'b1 : 1'b0;
    if (TAGN == 1) begin exp_d.push_back(int'(TAGB) + int'(ch)); exp_c.push_back(int'(ch)); end
    while (n < maxw && n < BL && (ch ? mq2.size() : mq1.size()) > 0) begin
      if (ch) exp_d.push_back(mq2.pop_front());
      else    exp_d.push_back(mq1.pop_front());
      exp_c.push_back(int'(ch));
      n++;
    end
    if (maxw >= BL) mptr = !ch;
  endtask

  task automatic model_all();
    while (mq1.size() > 0 || mq2.size() > 0) model_grant(BL);
  endtask

  bit rdy_force = 1'b1, rdy_val = 1'b0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      tx_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: transfers, stall hold, pop legality, one-cycle pop pulses.
  bit prev_hold = 1'b0, prev_rd1 = 1'b0, prev_rd2 = 1'b0;
  logic [DW-1:0] prev_d = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_hold) begin
          check_val("hold_valid", int'(tx_valid), 1);
          check_val("hold_data", int'(tx_data), int'(prev_d));
        end
        if (fifo1_rd_en) begin
          check_val("pop1_nonempty", int'(fifo1_empty), 0);
          check_val("rd1_pulse", int'(prev_rd1), 0);
          check_val("rd1_stalled", int'(prev_hold), 0);
        end
        if (fifo2_rd_en) begin
          check_val("pop2_nonempty", int'(fifo2_empty), 0);
          check_val("rd2_pulse", int'(prev_rd2), 0);
          check_val("rd2_stalled", int'(prev_hold), 0);
        end
        if (tx_valid && tx_ready) begin
          got_d.push_back(int'(tx_data));
          got_c.push_back(int'(active_ch));
          $display("tx %0d: ch=%0d data=%02h", got_d.size(), active_ch, tx_data);
        end
      end
      prev_hold = !rst && tx_valid && !tx_ready;
      prev_d    = tx_data;
      prev_rd1  = fifo1_rd_en;
      prev_rd2  = fifo2_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input int n, input string tag);
    int cyc = 0;
    while (got_d.size() < n && cyc < 3000) begin tick(); cyc++; end
    repeat (12) tick();
    check_val({tag, "_count"}, got_d.size(), n);
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!tx_valid && cyc < 100) begin tick(); cyc++; end
    check_val(tag, int'(tx_valid), 1);
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        check_val({tag, "_data"}, got_d[i], exp_d[i]);
        check_val({tag, "_ch"}, got_c[i], exp_c[i]);
      end
    end
    check_val({tag, "_busy_end"}, int'(busy), 0);
    check_val({tag, "_valid_end"}, int'(tx_valid), 0);
    exp_d.delete(); exp_c.delete(); got_d.delete(); got_c.delete();
  endtask

  initial begin
    int pops;
    logic [DW-1:0] held;
    rst = 1'b1; start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      load(0, DW'(i));
      load(1, DW'(2 * i));
    end
    repeat (3) tick();
    check_val("rst_valid", int'(tx_valid), 0);
    check_val("rst_data", int'(tx_data), 0);
    check_val("rst_ch", int'(active_ch), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_rd_en", int'(fifo1_rd_en) + int'(fifo2_rd_en), 0);
    check_val("rst_pops", rd1 + rd2, 0);
    rst = 1'b0;
    repeat (2) tick();
    check_val("idle_pops", rd1 + rd2, 0);

    // Fixed interleave: 1,2,3,4 / 2,4,6,8 / 5..8 / 10..16.
    model_all();
    rdy_val = 1'b1; start = 1'b1;
    wait_for(exp_d.size(), "fixed");
    compare("fixed");
    start = 1'b0; repeat (2) tick();

    // Serializer stalled for 20 cycles.
    load(0, DW'($urandom_range(0, 255)));
    model_all();
    rdy_val = 1'b0; start = 1'b1;
    wait_valid("stall_reach");
    held = tx_data;
    pops = rd1 + rd2;
    repeat (20) tick();
    check_val("stall_valid", int'(tx_valid), 1);
    check_val("stall_data", int'(tx_data), int'(held));
    check_val("stall_pops", rd1 + rd2, pops);
    rdy_val = 1'b1;
    wait_for(exp_d.size(), "stall");
    compare("stall");
    start = 1'b0; repeat (2) tick();

    // Random loads with random serializer back-pressure.
    for (int s = 0; s < 8; s++) begin
      int n1 = $urandom_range(0, 10);
      int n2 = $urandom_range(0, 10);
      for (int i = 0; i < n1; i++) load(0, DW'($urandom_range(0, 255)));
      for (int i = 0; i < n2; i++) load(1, DW'($urandom_range(0, 255)));
      model_all();
      rdy_force = 1'b0; start = 1'b1;
      wait_for(exp_d.size(), "rand");
      compare("rand");
      start = 1'b0; repeat (2) tick();
    end

    // start falls during the second word of a burst, then resumes.
    for (int i = 0; i < 6; i++) begin
      load(0, DW'($urandom_range(0, 255)));
      load(1, DW'($urandom_range(0, 255)));
    end
    model_grant(2);
    rdy_force = 1'b1; rdy_val = 1'b1; start = 1'b1;
    begin
      int cyc = 0;
      while (got_d.size() < TAGN + 1 && cyc < 200) begin tick(); cyc++; end
    end
    rdy_val = 1'b0;
    tick();
    wait_valid("drop_reach");
    start = 1'b0;
    tick();
    rdy_val = 1'b1;
    pops = rd1 + rd2;
    wait_for(exp_d.size(), "drop");
    check_val("drop_busy", int'(busy), 0);
    check_val("drop_pops", rd1 + rd2, pops);
    rdy_force = 1'b0; start = 1'b1;
    model_all();
    wait_for(exp_d.size(), "resume");
    compare("resume");
    start = 1'b0; repeat (2) tick();

    // Reset while a word waits in SEND.
    load(0, DW'($urandom_range(0, 255)));
    rdy_force = 1'b1; rdy_val = 1'b0; start = 1'b1;
    wait_valid("rst_send_reach");
    rst = 1'b1;
    tick();
    check_val("rst_send_valid", int'(tx_valid), 0);
    check_val("rst_send_busy", int'(busy), 0);
    check_val("rst_send_data", int'(tx_data), 0);
    check_val("rst_send_ch", int'(active_ch), 0);
    rst = 1'b0; start = 1'b0;
    void'(mq1.pop_front());
    mptr = 1'b0;
    got_d.delete(); got_c.delete();
    tick();

    // After reset channel 0 is preferred again.
    for (int i = 0; i < 5; i++) begin
      load(0, DW'($urandom_range(0, 255)));
      load(1, DW'($urandom_range(0, 255)));
    end
    model_all();
    rdy_force = 1'b0; start = 1'b1;
    wait_for(exp_d.size(), "post_rst");
    compare("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
